// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, ALU op codes and the entry FSM state type.
package calc_pkg;
   typedef enum logic [1:0] {S_NUM1, S_NUM2, S_WAIT, S_RESULT} state_t;

   localparam logic [0:3] KEY_PLUS  = 4'd10;
   localparam logic [0:3] KEY_MINUS = 4'd11;
   localparam logic [0:3] KEY_EQ    = 4'd12;
   localparam logic [0:3] KEY_CLR   = 4'd13;
   localparam logic [0:3] KEY_BS    = 4'd14;

   localparam logic [0:1] OP_ADD = 2'b00;
   localparam logic [0:1] OP_SUB = 2'b01;

   function automatic logic is_digit(input logic [0:3] k);
      return k <= 4'd9;
   endfunction
endpackage

// File: rtl/bcd_digit_reg.sv
// One BCD operand with its digit count; exposes next-state values so the owner can register
// derived outputs on the same edge. Shift-out exists only with OPERAND_ENTRY_BACKSPACE_EN.
module bcd_digit_reg #(
   parameter int DIGITS = 4,
   parameter int W      = 4*DIGITS,
   parameter int CW     = $clog2(DIGITS+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load,
   input  logic [0:W-1]  load_val,
   input  logic [CW-1:0] load_cnt,
   input  logic          shift_in,
   input  logic [0:3]    digit,
`ifdef OPERAND_ENTRY_BACKSPACE_EN
   input  logic          shift_out,
`endif
   output logic [0:W-1]  val,
   output logic [CW-1:0] cnt,
   output logic [0:W-1]  nxt_val,
   output logic [CW-1:0] nxt_cnt
);
   always_comb begin
      nxt_val = val;
      nxt_cnt = cnt;
      if (clear) begin
         nxt_val = '0;
         nxt_cnt = '0;
      end else if (load) begin
         nxt_val = load_val;
         nxt_cnt = load_cnt;
      end else if (shift_in) begin
         nxt_val = {val[4:W-1], digit};
         nxt_cnt = cnt + CW'(1);
      end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      else if (shift_out) begin
         nxt_val = {4'd0, val[0:W-5]};
         nxt_cnt = cnt - CW'(1);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val <= '0;
         cnt <= '0;
      end else begin
         val <= nxt_val;
         cnt <= nxt_cnt;
      end
   end
endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry FSM feeding a BCD ALU and a display driver.
// Optional backspace support is enabled by defining OPERAND_ENTRY_BACKSPACE_EN.
module operand_entry import calc_pkg::*; #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [0:3]          key,
   input  logic                key_valid,
   input  logic [0:4*DIGITS-1] alu_res,
   input  logic                alu_valid,
   output logic [0:4*DIGITS-1] num1,
   output logic [0:4*DIGITS-1] num2,
   output logic [0:1]          op,
   output logic [0:4*DIGITS-1] display,
   output logic                result_ready,
   output logic                entry_err
);
   localparam int W  = 4*DIGITS;
   localparam int CW = $clog2(DIGITS+1);
   localparam logic [CW-1:0] FULL = CW'(DIGITS);

   state_t        state, nxt_state;
   logic [0:W-1]  result, nxt_result, nxt_display;
   logic [0:1]    nxt_op;
   logic          err, clr;
   logic          n1_load, n1_shift, n2_shift, n2_clear;
   logic [0:W-1]  n1_load_val, n1_nxt, n2_nxt;
   logic [CW-1:0] n1_load_cnt, n1_cnt, n2_cnt, n1_nxt_cnt, n2_nxt_cnt;
   logic          op_key;
   logic [0:1]    key_op;
   logic          unused_n1_cnt;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
   logic          n1_bs, n2_bs;
`endif

   assign op_key        = (key == KEY_PLUS) || (key == KEY_MINUS);
   assign key_op        = (key == KEY_MINUS) ? OP_SUB : OP_ADD;
   assign unused_n1_cnt = ^n1_nxt_cnt;

   always_comb begin
      nxt_state   = state;
      nxt_op      = op;
      nxt_result  = result;
      err         = 1'b0;
      clr         = 1'b0;
      n1_load     = 1'b0;
      n1_load_val = result;
      n1_load_cnt = FULL;
      n1_shift    = 1'b0;
      n2_shift    = 1'b0;
      n2_clear    = 1'b0;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      n1_bs       = 1'b0;
      n2_bs       = 1'b0;
`endif
      if (key_valid && key == KEY_CLR) begin
         clr        = 1'b1;
         nxt_state  = S_NUM1;
         nxt_op     = OP_ADD;
         nxt_result = '0;
      end else begin
         case (state)
            S_NUM1: if (key_valid) begin
               if (is_digit(key)) begin
                  if (n1_cnt == FULL) err = 1'b1;
                  else                n1_shift = 1'b1;
               end else if (op_key) begin
                  nxt_op    = key_op;
                  n2_clear  = 1'b1;
                  nxt_state = S_NUM2;
               end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
               else if (key == KEY_BS) begin
                  if (n1_cnt == '0) err = 1'b1;
                  else              n1_bs = 1'b1;
               end
`endif
               else err = 1'b1;
            end
            S_NUM2: if (key_valid) begin
               if (is_digit(key)) begin
                  if (n2_cnt == FULL) err = 1'b1;
                  else                n2_shift = 1'b1;
               end else if (op_key) begin
                  // operator can only be changed before any num2 digit is typed
                  if (n2_cnt == '0) nxt_op = key_op;
                  else              err = 1'b1;
               end else if (key == KEY_EQ) begin
                  nxt_state = S_WAIT;
               end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
               else if (key == KEY_BS) begin
                  if (n2_cnt == '0) err = 1'b1;
                  else              n2_bs = 1'b1;
               end
`endif
               else err = 1'b1;
            end
            S_WAIT: begin
               if (key_valid) err = 1'b1;
               if (alu_valid) begin
                  nxt_result = alu_res;
                  nxt_state  = S_RESULT;
               end
            end
            S_RESULT: if (key_valid) begin
               if (is_digit(key)) begin
                  n1_load     = 1'b1;
                  n1_load_val = {{(W-4){1'b0}}, key};
                  n1_load_cnt = CW'(1);
                  n2_clear    = 1'b1;
                  nxt_state   = S_NUM1;
               end else if (op_key) begin
                  // chain: previous result becomes a full-width num1
                  n1_load   = 1'b1;
                  nxt_op    = key_op;
                  n2_clear  = 1'b1;
                  nxt_state = S_NUM2;
               end else err = 1'b1;
            end
            default: nxt_state = S_NUM1;
         endcase
      end
   end

   always_comb begin
      case (nxt_state)
         S_NUM2:   nxt_display = (n2_nxt_cnt == '0) ? n1_nxt : n2_nxt;
         S_RESULT: nxt_display = nxt_result;
         default:  nxt_display = n1_nxt;
      endcase
   end

   bcd_digit_reg #(.DIGITS(DIGITS)) u_num1 (
      .clk      (clk),
      .rst      (rst),
      .clear    (clr),
      .load     (n1_load),
      .load_val (n1_load_val),
      .load_cnt (n1_load_cnt),
      .shift_in (n1_shift),
      .digit    (key),
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      .shift_out(n1_bs),
`endif
      .val      (num1),
      .cnt      (n1_cnt),
      .nxt_val  (n1_nxt),
      .nxt_cnt  (n1_nxt_cnt)
   );

   bcd_digit_reg #(.DIGITS(DIGITS)) u_num2 (
      .clk      (clk),
      .rst      (rst),
      .clear    (clr | n2_clear),
      .load     (1'b0),
      .load_val ('0),
      .load_cnt ('0),
      .shift_in (n2_shift),
      .digit    (key),
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      .shift_out(n2_bs),
`endif
      .val      (num2),
      .cnt      (n2_cnt),
      .nxt_val  (n2_nxt),
      .nxt_cnt  (n2_nxt_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_NUM1;
         op           <= OP_ADD;
         result       <= '0;
         display      <= '0;
         result_ready <= 1'b0;
         entry_err    <= 1'b0;
      end else begin
         state        <= nxt_state;
         op           <= nxt_op;
         result       <= nxt_result;
         display      <= nxt_display;
         result_ready <= (nxt_state == S_RESULT);
         entry_err    <= err;
      end
   end
endmodule

// File: tb/tb_operand_entry.sv
// Directed vector bench for operand_entry with a decimal-arithmetic ALU model.
module tb_operand_entry;
   localparam logic [3:0] K_PLUS = 4'd10, K_MINUS = 4'd11, K_EQ = 4'd12, K_CLR = 4'd13, K_BS = 4'd14;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [0:3]  key = '0;
   logic        key_valid = 1'b0;
   logic [0:15] alu_res;
   logic        alu_valid;
   logic        alu_en = 1'b1;
   logic [0:15] num1, num2, display;
   logic [0:1]  op;
   logic        result_ready, entry_err;

   int checks = 0;
   int errors = 0;

   operand_entry #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst), .key(key), .key_valid(key_valid),
      .alu_res(alu_res), .alu_valid(alu_valid),
      .num1(num1), .num2(num2), .op(op), .display(display),
      .result_ready(result_ready), .entry_err(entry_err)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r*10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int x);
      logic [15:0] r = '0;
      int t = x;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o);
      int a = bcd2int(x);
      int b = bcd2int(y);
      int r = (o == 2'b01) ? (a - b + 10000) % 10000 : (a + b) % 10000;
      return int2bcd(r);
   endfunction

   always_comb begin
      alu_res   = alu_fn(num1, num2, op);
      alu_valid = alu_en;
   end

   typedef struct {
      logic        r;
      logic        kv;
      logic [3:0]  k;
      logic [15:0] n1, n2, d;
      logic [1:0]  o;
      logic        rr, er;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic kv, input logic [3:0] k,
                               input logic [15:0] n1, input logic [15:0] n2, input logic [15:0] d,
                               input logic [1:0] o, input logic rr, input logic er);
      vec_t v;
      v.r = r; v.kv = kv; v.k = k; v.n1 = n1; v.n2 = n2; v.d = d; v.o = o; v.rr = rr; v.er = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic kv, input logic [3:0] k);
      @(negedge clk);
      rst = r; key_valid = kv; key = k;
      @(posedge clk);
      #1;
   endtask

   vec_t vt[35];

   initial begin
      //         rst kv key      num1      num2      display   op rr err
      vt[0]  = mk(1, 1, 4'd5,    16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      vt[1]  = mk(0, 1, 4'd1,    16'h0001, 16'h0000, 16'h0001, 0, 0, 0);
      vt[2]  = mk(0, 1, 4'd2,    16'h0012, 16'h0000, 16'h0012, 0, 0, 0);
      vt[3]  = mk(0, 1, 4'd3,    16'h0123, 16'h0000, 16'h0123, 0, 0, 0);
      vt[4]  = mk(0, 1, 4'd4,    16'h1234, 16'h0000, 16'h1234, 0, 0, 0);
      vt[5]  = mk(0, 1, 4'd5,    16'h1234, 16'h0000, 16'h1234, 0, 0, 1);
      vt[6]  = mk(0, 0, 4'd0,    16'h1234, 16'h0000, 16'h1234, 0, 0, 0);
      vt[7]  = mk(1, 0, 4'd0,    16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      vt[8]  = mk(0, 1, 4'd7,    16'h0007, 16'h0000, 16'h0007, 0, 0, 0);
      vt[9]  = mk(0, 1, K_PLUS,  16'h0007, 16'h0000, 16'h0007, 0, 0, 0);
      vt[10] = mk(0, 1, 4'd8,    16'h0007, 16'h0008, 16'h0008, 0, 0, 0);
      vt[11] = mk(0, 1, K_EQ,    16'h0007, 16'h0008, 16'h0007, 0, 0, 0);
      vt[12] = mk(0, 0, 4'd0,    16'h0007, 16'h0008, 16'h0015, 0, 1, 0);
      vt[13] = mk(0, 0, 4'd0,    16'h0007, 16'h0008, 16'h0015, 0, 1, 0);
      vt[14] = mk(0, 1, K_MINUS, 16'h0015, 16'h0000, 16'h0015, 1, 0, 0);
      vt[15] = mk(0, 1, 4'd5,    16'h0015, 16'h0005, 16'h0005, 1, 0, 0);
      vt[16] = mk(0, 1, K_EQ,    16'h0015, 16'h0005, 16'h0015, 1, 0, 0);
      vt[17] = mk(0, 0, 4'd0,    16'h0015, 16'h0005, 16'h0010, 1, 1, 0);
      vt[18] = mk(0, 1, K_EQ,    16'h0015, 16'h0005, 16'h0010, 1, 1, 1);
      vt[19] = mk(0, 1, 4'd9,    16'h0009, 16'h0000, 16'h0009, 1, 0, 0);
      vt[20] = mk(0, 1, K_EQ,    16'h0009, 16'h0000, 16'h0009, 1, 0, 1);
      vt[21] = mk(0, 1, K_MINUS, 16'h0009, 16'h0000, 16'h0009, 1, 0, 0);
      vt[22] = mk(0, 1, K_PLUS,  16'h0009, 16'h0000, 16'h0009, 0, 0, 0);
      vt[23] = mk(0, 1, 4'd3,    16'h0009, 16'h0003, 16'h0003, 0, 0, 0);
      vt[24] = mk(0, 1, K_MINUS, 16'h0009, 16'h0003, 16'h0003, 0, 0, 1);
      vt[25] = mk(0, 1, 4'd15,   16'h0009, 16'h0003, 16'h0003, 0, 0, 1);
      vt[26] = mk(0, 1, K_EQ,    16'h0009, 16'h0003, 16'h0009, 0, 0, 0);
      vt[27] = mk(0, 0, 4'd0,    16'h0009, 16'h0003, 16'h0012, 0, 1, 0);
      vt[28] = mk(0, 1, K_MINUS, 16'h0012, 16'h0000, 16'h0012, 1, 0, 0);
      vt[29] = mk(0, 1, 4'd5,    16'h0012, 16'h0005, 16'h0005, 1, 0, 0);
      vt[30] = mk(0, 1, 4'd0,    16'h0012, 16'h0050, 16'h0050, 1, 0, 0);
      vt[31] = mk(0, 1, K_EQ,    16'h0012, 16'h0050, 16'h0012, 1, 0, 0);
      vt[32] = mk(0, 0, 4'd0,    16'h0012, 16'h0050, 16'h9962, 1, 1, 0);
      vt[33] = mk(0, 1, K_CLR,   16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      vt[34] = mk(0, 1, 4'd4,    16'h0004, 16'h0000, 16'h0004, 0, 0, 0);

      foreach (vt[i]) begin
         step(vt[i].r, vt[i].kv, vt[i].k);
         chk($sformatf("v%0d num1", i),    num1,                 vt[i].n1);
         chk($sformatf("v%0d num2", i),    num2,                 vt[i].n2);
         chk($sformatf("v%0d display", i), display,              vt[i].d);
         chk($sformatf("v%0d op", i),      16'(op),              16'(vt[i].o));
         chk($sformatf("v%0d ready", i),   16'(result_ready),    16'(vt[i].rr));
         chk($sformatf("v%0d err", i),     16'(entry_err),       16'(vt[i].er));
      end

      // ALU stalled: keys rejected in S_WAIT, clear aborts the operation
      alu_en = 1'b0;
      step(1, 0, 0);
      step(0, 1, 4'd1);
      step(0, 1, K_MINUS);
      step(0, 1, 4'd2);
      step(0, 1, K_EQ);
      chk("wait ready0", 16'(result_ready), 16'h0);
      step(0, 1, 4'd3);
      chk("wait key3 err", 16'(entry_err), 16'h1);
      chk("wait key3 disp", display, 16'h0001);
      chk("wait key3 num2", num2, 16'h0002);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      chk("wait stall ready", 16'(result_ready), 16'h0);
      chk("wait stall err", 16'(entry_err), 16'h0);
      step(0, 1, K_CLR);
      chk("clr num1", num1, 16'h0000);
      chk("clr num2", num2, 16'h0000);
      chk("clr disp", display, 16'h0000);
      chk("clr op", 16'(op), 16'h0);
      chk("clr ready", 16'(result_ready), 16'h0);
      chk("clr err", 16'(entry_err), 16'h0);
      alu_en = 1'b1;
      step(0, 1, 4'd6);
      chk("post clr num1", num1, 16'h0006);

`ifdef OPERAND_ENTRY_BACKSPACE_EN
      step(1, 0, 0);
      step(0, 1, 4'd4);
      step(0, 1, 4'd2);
      chk("bs pre", num1, 16'h0042);
      step(0, 1, K_BS);
      chk("bs1 num1", num1, 16'h0004);
      chk("bs1 err", 16'(entry_err), 16'h0);
      step(0, 1, K_BS);
      chk("bs2 num1", num1, 16'h0000);
      chk("bs2 err", 16'(entry_err), 16'h0);
      step(0, 1, K_BS);
      chk("bs3 num1", num1, 16'h0000);
      chk("bs3 err", 16'(entry_err), 16'h1);
      // count after one backspace from two digits must be 1: three more fit, a fourth does not
      step(1, 0, 0);
      step(0, 1, 4'd4);
      step(0, 1, 4'd2);
      step(0, 1, K_BS);
      step(0, 1, 4'd5);
      step(0, 1, 4'd6);
      step(0, 1, 4'd7);
      chk("bs cnt fill", num1, 16'h4567);
      chk("bs cnt fill err", 16'(entry_err), 16'h0);
      step(0, 1, 4'd8);
      chk("bs cnt full", num1, 16'h4567);
      chk("bs cnt full err", 16'(entry_err), 16'h1);
`else
      step(1, 0, 0);
      step(0, 1, 4'd4);
      step(0, 1, K_BS);
      chk("bs rej num1", num1, 16'h0004);
      chk("bs rej err", 16'(entry_err), 16'h1);
`endif
      step(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
